// File: rtl/axis_uart_tx.sv
// axis_uart_tx: byte-stream to serial UART transmitter (8 data bits, LSB
// first, 1 or 2 stop bits). A one-byte holding register lets frames run back
// to back with no idle bit between them.
module axis_uart_tx #(
  parameter int DIVISOR   = 16,  // clock cycles per bit period, >= 1
  parameter int STOP_BITS = 1    // 1 or 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] idata,
  input  logic       ivalid,
  output logic       iready,
  output logic       txd,
  output logic       busy
);

  // Handshake: a byte moves on a rising edge where ivalid && iready. iready
  // depends only on the holding register and reset, never on ivalid, and
  // idata is ignored whenever ivalid is low. ivalid may be withdrawn freely.

  // Wide enough to hold DIVISOR-1 even when DIVISOR == 1.
  localparam int BW = $clog2(DIVISOR + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;

  logic            xfer;
  logic            baud_end;
  logic            last_stop;
  logic            direct_load;

  assign iready = !hold_valid_q && !reset;
  assign txd    = txd_q;
  assign busy   = busy_q;

  // Next-state logic for the frame engine, holding register and outputs.
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    txd_d        = txd_q;

    xfer      = ivalid && iready;
    baud_end  = (baud_q == BW'(DIVISOR - 1));
    last_stop = (state_q == S_STOP) && baud_end && (bit_q == 3'(STOP_BITS - 1));
    // A byte arriving exactly as the last stop period ends (holding register
    // empty) goes straight into the shifter so it is neither lost nor delayed.
    direct_load = xfer && ((state_q == S_IDLE) || last_stop);

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (xfer) begin
          state_d = S_START;
          shift_d = idata;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = '0;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (last_stop) begin
            bit_d = '0;
            if (hold_valid_q) begin
              state_d      = S_START;
              shift_d      = hold_q;
              hold_valid_d = 1'b0;
              txd_d        = 1'b0;
            end else if (xfer) begin
              state_d = S_START;
              shift_d = idata;
              txd_d   = 1'b0;
            end else begin
              state_d = S_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Any accepted byte that did not go straight into the shifter is parked.
    if (xfer && !direct_load) begin
      hold_d       = idata;
      hold_valid_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE) || hold_valid_d;
  end

  // State and registered outputs; reset aborts any frame and drops the held byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: doc/axis_uart_tx.md
Name: axis_uart_tx

Overview:
- Stream-to-serial UART transmitter placed directly downstream of axis_fifo; consumes its odata/ovalid/oready byte stream.
- Serialises each byte as an 8N1 (or 8N2) frame on txd.
- A one-byte holding register lets frames run back-to-back with no idle gap, so the FIFO can drain at full line rate.

Parameters:
- DIVISOR, 16, clock cycles per bit period; legal range ≥1.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous reset, active high.
- idata  input  8  byte to transmit (AXI-stream data).
- ivalid  input  1  idata valid.
- iready  output  1  block accepts idata this cycle.
- txd  output  1  serial line; idles high.
- busy  output  1  a frame is in progress or a byte is held.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values, registered: txd=1, busy=0, engine IDLE, holding register empty, all counters 0.
- iready = !hold_valid && !reset (combinational), so iready=0 during reset and 1 the cycle after.
- Handshake: a byte is transferred on a rising edge where ivalid && iready. idata is ignored when ivalid=0. ivalid may drop without a transfer; no AXI-stream stability rule is enforced on the input.
- Engine states: IDLE, START, DATA, STOP.
  - Baud counter runs 0..DIVISOR-1.
  - Bit counter runs 0..7 in DATA and 0..STOP_BITS-1 in STOP.
- Direct load: a transfer while the engine is IDLE and the holding register is empty loads the byte straight into the shift register, bypassing the holding register.
  - State becomes START and txd=0 from the next cycle, i.e. 1-cycle latency from the handshake to the start-bit edge.
  - The holding register stays empty, so iready remains 1.
- Held load: a transfer while the engine is busy stores the byte in the holding register and sets hold_valid.
- Bit timing: txd holds each bit for exactly DIVISOR cycles.
  - Order: START (0), DATA bits 0..7 LSB first, then STOP (1) for STOP_BITS periods.
  - Frame length = (9+STOP_BITS)*DIVISOR cycles.
- End of the last stop period:
  - If hold_valid: load the shift register from the holding register, clear hold_valid, enter START. The next start bit begins on the very next cycle (zero idle gap). iready returns to 1 the cycle after that load edge.
  - Else: enter IDLE with txd=1.
- busy = (state != IDLE) || hold_valid, registered consistently with txd so that busy=0 exactly when txd is idle-high and nothing is pending.
- DIVISOR=1: each bit lasts one cycle; frame = 9+STOP_BITS cycles; back-to-back operation still gapless.
- Reset mid-frame: the frame is aborted and the held byte is discarded. txd=1, busy=0 after the reset edge, with no glitch to 0 after that edge.
- Width rule: baud counter is $clog2(DIVISOR+1) bits wide, so DIVISOR=1 still works.

Test Plan:
- Single byte, DIVISOR=4, STOP_BITS=1:
  - Stimulus: send 0xA5 from idle.
  - Response: txd=0 for cycles 1-4 after the handshake; then 1,0,1,0,0,1,0,1 for 4 cycles each; then 1 for 4 cycles.
  - busy falls 40 cycles after the handshake; iready stays 1 throughout.
- Back-to-back from axis_fifo (SIZE=7) fed by axis_counter, DIVISOR=4:
  - Bytes 0x00, 0x01, 0x02 are sent.
  - txd shows three contiguous 40-cycle frames with no idle cycle between them; busy stays 1 for 120 cycles.
- Backpressure:
  - Stimulus: ivalid held at 1 with DIVISOR=4.
  - Response: first byte direct-loads; second is held and iready=0; iready stays low until the frame-1 stop bit ends.
  - Exactly one new transfer per 40 cycles; no byte lost or duplicated (check the decoded sequence against the counter).
- STOP_BITS=2, DIVISOR=4:
  - Stimulus: send 0xFF.
  - Response: txd=0 for 4 cycles, then 1 for 40 cycles; next frame start no earlier than 44 cycles after the first start edge.
- DIVISOR=1:
  - Stimulus: send 0x3C then 0xC3 back-to-back.
  - Response: txd = 0,0,0,1,1,1,1,0,0,1, 0,1,1,0,0,0,0,1,1,1, then idle 1.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle during DATA bit 3, with a byte held.
  - Response: txd=1, busy=0, iready=0 during reset and 1 after; the held byte is never transmitted.
  - A new byte sent afterwards produces a clean frame.
